// File: rtl/kypd_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner.
// Holds the default timing parameters, the frame-class encoding and the
// key map that turns a snapshot bit position (4*row + col) into a hex code.
package kypd_pkg;

  localparam int DEFAULT_SCAN_DIV        = 100000;
  localparam int DEFAULT_DEBOUNCE_FRAMES = 4;

  typedef enum logic [1:0] {
    CLS_NONE  = 2'd0,
    CLS_KEY   = 2'd1,
    CLS_MULTI = 2'd2
  } frame_class_t;

  // Nibble i holds the hex code for snapshot bit i (bit index = 4*r + c).
  // Rows from the top: 1 2 3 A / 4 5 6 B / 7 8 9 C / 0 F E D.
  localparam logic [63:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic logic [3:0] key_lookup(input logic [3:0] idx);
    return KEY_MAP[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/keypad_decode.sv
// Combinational frame classifier for a 16-bit keypad snapshot.
// Ports: snap (bit 4*r+c set = key pressed), cls (NONE/KEY/MULTI),
//        code (hex code of the single pressed key; only meaningful for KEY).
module keypad_decode
  import kypd_pkg::*;
(
  input  logic [15:0]  snap,
  output frame_class_t cls,
  output logic [3:0]   code
);

  logic [4:0] ones;
  logic [3:0] idx;

  always_comb begin
    ones = '0;
    idx  = '0;
    for (int i = 0; i < 16; i++) begin
      if (snap[i]) begin
        ones = ones + 5'd1;
        idx  = 4'(i);
      end
    end

    if (ones == 5'd0) begin
      cls = CLS_NONE;
    end else if (ones == 5'd1) begin
      cls = CLS_KEY;
    end else begin
      cls = CLS_MULTI;
    end

    code = key_lookup(idx);
  end

endmodule

// File: rtl/keypad_scan.sv
// Column-strobed 4x4 keypad reader with whole-frame debounce and one-pulse output.
// Ports: clk, rst (async active-low), row (active-low, async), col (active-low strobe),
//        key_code (last accepted key), key_valid (1-cycle pulse), key_held (key down).
module keypad_scan
  import kypd_pkg::*;
#(
  parameter int SCAN_DIV        = DEFAULT_SCAN_DIV,
  parameter int DEBOUNCE_FRAMES = DEFAULT_DEBOUNCE_FRAMES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_FRAMES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  logic [DIV_W-1:0] div;
  logic [1:0]       c;
  logic [15:0]      snap;
  logic [15:0]      snap_next;
  logic             col_last;
  logic             frame_end;

  frame_class_t     frm_cls;
  logic [3:0]       frm_code;
  frame_class_t     prev_cls;
  logic [3:0]       prev_code;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             same_frame;
  logic             stable;
  state_t           state;

  // Rows are pulled up, so the synchronizer idles at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  assign col_last  = (div == DIV_LAST);
  assign frame_end = col_last && (c == 2'd3);
  assign col       = ~(4'b0001 << c);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div  <= '0;
      c    <= 2'd0;
      snap <= '0;
    end else begin
      snap <= snap_next;
      if (col_last) begin
        div <= '0;
        c   <= c + 2'd1;
      end else begin
        div <= div + DIV_W'(1);
      end
    end
  end

  // The last column's sample is merged combinationally so the frame can be
  // classified in the same cycle it completes.
  always_comb begin
    snap_next = snap;
    if (col_last) begin
      for (int r = 0; r < 4; r++) begin
        snap_next[{2'(r), c}] = ~row_sync[r];
      end
    end
  end

  keypad_decode u_decode (
    .snap (snap_next),
    .cls  (frm_cls),
    .code (frm_code)
  );

  // Two KEY frames only match when they carry the same key, so a direct
  // rollover restarts the count instead of being accepted instantly.
  always_comb begin
    same_frame = (frm_cls == prev_cls) &&
                 ((frm_cls != CLS_KEY) || (frm_code == prev_code));
    if (frm_cls == CLS_MULTI) begin
      cnt_next = '0;
    end else if (same_frame) begin
      cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    end else begin
      cnt_next = CNT_W'(1);
    end
    stable = (frm_cls != CLS_MULTI) && (cnt_next == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      prev_cls  <= CLS_NONE;
      prev_code <= 4'h0;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_end) begin
        cnt       <= cnt_next;
        prev_cls  <= frm_cls;
        prev_code <= frm_code;
        if (stable) begin
          case (state)
            ST_IDLE: begin
              if (frm_cls == CLS_KEY) begin
                state     <= ST_HELD;
                key_code  <= frm_code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
              end
            end
            ST_HELD: begin
              if (frm_cls == CLS_KEY && frm_code != key_code) begin
                key_code  <= frm_code;
                key_valid <= 1'b1;
              end else if (frm_cls == CLS_NONE) begin
                state    <= ST_IDLE;
                key_held <= 1'b0;
              end
            end
            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Randomized and directed bench for keypad_scan against a frame-level model.
module tb_keypad_scan;

  localparam int SD    = 8;
  localparam int DF    = 2;
  localparam int FRAME = 4 * SD;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [15:0] pressed = '0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // Passive matrix: a pressed key shorts its row to its column.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int cc = 0; cc < 4; cc++)
        if (pressed[4*r+cc] && !col[cc]) row[r] = 1'b0;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Frame-level reference: key value per (row, col) read straight off the keypad legend.
  int keymap [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 0, 15, 14, 13};
  bit m_held;
  int m_code;
  int m_cnt;
  int m_prev_kind;   // 0 none, 1 single key, 2 several keys
  int m_prev_key;
  bit m_pulse;

  function automatic void model_reset();
    m_held = 0; m_code = 0; m_cnt = 0; m_prev_kind = 0; m_prev_key = 0; m_pulse = 0;
  endfunction

  function automatic void model_frame(input logic [15:0] s);
    int n, kind, key;
    bit same;
    n = $countones(s);
    kind = (n == 0) ? 0 : (n == 1) ? 1 : 2;
    key = 0;
    for (int i = 0; i < 16; i++) if (s[i]) key = keymap[i];
    same = (kind == m_prev_kind) && (kind != 1 || key == m_prev_key);
    if (kind == 2) m_cnt = 0;
    else if (same) m_cnt = (m_cnt + 1 > DF) ? DF : m_cnt + 1;
    else m_cnt = 1;
    m_prev_kind = kind;
    m_prev_key  = key;
    m_pulse = 0;
    if (kind != 2 && m_cnt == DF) begin
      if (kind == 1 && (!m_held || key != m_code)) begin
        m_held = 1; m_code = key; m_pulse = 1;
      end else if (kind == 0 && m_held) begin
        m_held = 0;
      end
    end
  endfunction

  // Keys change at the start of column 0, so the whole frame sees one pattern.
  task automatic run_frame(input logic [15:0] keys);
    logic [3:0] ec;
    pressed = keys;
    model_frame(keys);
    for (int i = 1; i <= FRAME; i++) begin
      @(posedge clk); #1;
      ec = ~(4'b0001 << ((i % FRAME) / SD));
      chk("col", 16'(col), 16'(ec));
      if (i < FRAME) chk("valid_mid", 16'(key_valid), 16'(0));
    end
    chk("valid", 16'(key_valid), 16'(m_pulse));
    chk("held",  16'(key_held),  16'(m_held));
    chk("code",  16'(key_code),  16'(m_code));
  endtask

  task automatic run_n(input logic [15:0] keys, input int n);
    for (int i = 0; i < n; i++) run_frame(keys);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_col"},   16'(col),       16'h000E);
    chk({tag, "_code"},  16'(key_code),  16'(0));
    chk({tag, "_valid"}, 16'(key_valid), 16'(0));
    chk({tag, "_held"},  16'(key_held),  16'(0));
  endtask

  localparam logic [15:0] K1 = 16'h0001;
  localparam logic [15:0] K2 = 16'h0002;
  localparam logic [15:0] KA = 16'h0008;
  localparam logic [15:0] K5 = 16'h0020;
  localparam logic [15:0] KF = 16'h2000;
  localparam logic [15:0] KD = 16'h8000;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] pat;
    model_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    rst = 1'b1;
    #1 check_reset_outputs("after_release");
    @(negedge clk);
    rst = 1'b0;
    #1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();

    // press and release '5'
    run_n(K5, 6);
    run_n(16'h0, 3);
    // bouncing 'A'
    for (int i = 0; i < 4; i++) begin
      run_frame(KA);
      run_frame(16'h0);
    end
    // '1'+'2' together, then drop '2'
    run_n(K1 | K2, 5);
    run_n(K1, 3);
    run_n(16'h0, 3);
    // rollover A -> D
    run_n(KA, 3);
    run_n(KD, 3);
    run_n(16'h0, 3);
    // reset while 'F' is held
    run_n(KF, 3);
    repeat ($urandom_range(1, 25)) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1 check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    run_n(KF, 3);
    run_n(16'h0, 2);

    // random press patterns held for random frame counts
    for (int seg = 0; seg < 16; seg++) begin
      case ($urandom_range(0, 3))
        0: pat = 16'h0;
        1, 2: pat = 16'(1) << $urandom_range(0, 15);
        default: pat = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      endcase
      run_n(pat, $urandom_range(1, 4));
    end
    run_n(16'h0, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scanning reader for a 4x4 matrix keypad (Pmod KYPD style) on the board's Pmod header. It drives one active-low column strobe at a time, samples the pulled-up row lines, and debounces over whole scan frames. It emits a 4-bit hex key code with a one-cycle `key_valid` pulse per accepted press. It is the input-side counterpart of the multiplexed 7-segment scanner, and its pulse output feeds the game FSM directly, so no separate debounce/one-pulse chain is needed.

## Interface
- `SCAN_DIV`, 100000: clk cycles each column is driven (1 ms at 100 MHz); must be ≥ 4.
- `DEBOUNCE_FRAMES`, 4: consecutive identical frames required to accept a press or a release; must be ≥ 1.
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: asynchronous, active-low reset.
- `row` in 4: keypad row lines, active-low (pulled up); asynchronous to `clk`.
- `col` out 4: column strobes, active-low, exactly one bit low at all times.
- `key_code` out 4: hex code of the accepted key; holds its last value after release.
- `key_valid` out 1: one-cycle pulse when a new key is accepted.
- `key_held` out 1: high while an accepted key is held.

## Operation
- `row` passes through a 2-FF synchronizer before any use.
- Column index `c` (0..3) advances every `SCAN_DIV` cycles and wraps 3→0. `col = ~(4'b0001 << c)`.
- Sample synchronized `row` in the last cycle of each column period, giving `SCAN_DIV-3` cycles of settling after the sync delay. Store the sample into a 16-bit frame snapshot, bit `4*r + c` = ~row[r].
- At the end of column 3 (frame end), classify the frame:
  - NONE: no bits set.
  - KEY(k): exactly one bit set.
  - MULTI: two or more bits set.
- Key map by (r,c):
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: 0,F,E,D
- Stability counter:
  - Increments when the frame class equals the previous frame class, saturating at `DEBOUNCE_FRAMES`.
  - Otherwise resets to 1.
  - MULTI always resets it to 0 and never changes the accepted state.
- Accepted state is IDLE or HELD(k):
  - IDLE + counter reaches `DEBOUNCE_FRAMES` on KEY(k) → HELD(k); `key_code=k`, pulse `key_valid`.
  - HELD(k) + counter reaches `DEBOUNCE_FRAMES` on KEY(j), j≠k → HELD(j); `key_code=j`, pulse `key_valid`.
  - HELD(k) + counter reaches `DEBOUNCE_FRAMES` on NONE → IDLE; no pulse, `key_code` retained.
  - A stable KEY(k) while already in HELD(k) produces no further pulses (no auto-repeat).
- `key_held` = (state == HELD).

## Timing
- Reset values:
  - `col=4'b1110`, `c=0`
  - `key_code=0`, `key_valid=0`, `key_held=0`
  - state IDLE, snapshot 0, stability counter 0, previous class NONE
- Reset is asynchronous. Asserting it mid-frame discards the partial frame and any partial debounce. The first full frame starts at `c=0` after release.
- Frame length is `4*SCAN_DIV` cycles. Classification and state update happen in the frame-end cycle. `key_valid`, `key_code` and `key_held` are registered and change one cycle later.
- Press latency from a stable press covering a full frame: accepted at the end of the `DEBOUNCE_FRAMES`-th such frame, plus 1 cycle. A press that begins mid-frame may need one extra frame.
- Release latency follows the same rule using NONE frames.
- `key_valid` is never high for two consecutive cycles. `key_valid` and a release never coincide.

## Structure
- Shared package `kypd_pkg` holds:
  - the 16-entry key-map constant
  - the frame-class encoding (NONE/KEY/MULTI)
  - the default `SCAN_DIV` and `DEBOUNCE_FRAMES` values
- Sub-module `keypad_decode`: purely combinational. Takes the 16-bit snapshot and outputs class and code. It is reusable by the testbench's reference model.
- The top of `keypad_scan` contains:
  - synchronizer
  - column/divider counters
  - snapshot register
  - debounce counter
  - accepted-state FSM

## Test plan
Bench uses `SCAN_DIV=8`, `DEBOUNCE_FRAMES=2` and a keypad model that pulls `row[r]` low when `col[c]` is low and key (r,c) is pressed.
- Reset: hold `rst=0`, then release → `col=1110`, all outputs 0. `col` cycles 1110→1101→1011→0111 every 8 cycles.
- Press '5' (r1,c1) for 6 frames → after 2 full frames `key_code=5`, exactly one `key_valid` pulse, `key_held=1`. Release → `key_held=0` after 2 NONE frames, no pulse, `key_code` stays 5.
- Bounce: press 'A' for 1 frame, release for 1 frame, repeated 4 times → no `key_valid`, `key_held` stays 0.
- Multi: hold '1' and '2' together for 5 frames → no pulse, state unchanged. Then release '2' → '1' accepted after 2 frames with one pulse.
- Rollover: hold 'A' until accepted, then switch directly to 'D' → second pulse with `key_code=D`, `key_held` never drops.
- Reset mid-operation: assert `rst` while 'F' is HELD → outputs 0 immediately. Keep 'F' pressed → re-accepted with a new pulse 2 full frames after reset release.
